viewport_mapper: RTL and testbench

- Downstream stage of the Q8.8 transform unit. Consumes each transformed vertex (x, y, one-cycle valid pulse) and maps world coordinates to integer screen pixels, with origin at screen centre and +y up.
- Clips vertices that fall outside the screen and computes the linear framebuffer address.
- Buffers accepted pixels in a small FIFO with a valid/ready output toward the framebuffer writer, so back-pressure never stalls the transform unit.

---
 rtl/graphics_pkg.sv | 19 +
 rtl/pixel_fifo.sv | 49 ++++
 rtl/viewport_mapper.sv | 133 +++++++++++++
 tb/tb_viewport_mapper.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graphics_pkg.sv
// Shared graphics definitions: Q8.8 constants,
// default screen geometry and the pixel entry layout.
package graphics_pkg;

  localparam int FRAC_BITS = 8;
  localparam logic [15:0] Q_HALF = 16'h0080;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_COORD_W  = 8;
  localparam int DEF_ADDR_W   = 15;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_ADDR_W-1:0]  addr;
  } pix_t;

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through FIFO with occupancy output.
// A push while full is taken only if a pop happens the same cycle.
module pixel_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = level != '0;
  assign full    = level == LW'(DEPTH);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/viewport_mapper.sv
// Maps Q8.8 world vertices to screen pixels, clips off-screen
// vertices and queues the survivors for the framebuffer writer.
module viewport_mapper
  import graphics_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int COORD_WIDTH = DEF_COORD_W,
  parameter int ADDR_WIDTH  = DEF_ADDR_W,
  parameter int FIFO_DEPTH  = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic                  clr_stats,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COORD_WIDTH-1:0] pix_x,
  output logic [COORD_WIDTH-1:0] pix_y,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic [LW-1:0]         fifo_level,
  output logic [15:0]           clipped_count,
  output logic                  overflow
);

  localparam int SW = 11;
  localparam int EW = DATA_WIDTH + 1;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [ADDR_WIDTH-1:0]  addr;
  } ent_t;

  logic signed [EW-1:0] xe;
  logic signed [EW-1:0] ye;
  logic signed [EW-1:0] xr;
  logic signed [EW-1:0] yr;
  logic signed [SW-1:0] sx;
  logic signed [SW-1:0] sy;
  logic                 clip;

  // Half-up rounding; the extra bit keeps 0x7FFF+0x80 from wrapping
  assign xe = EW'($signed(x_in));
  assign ye = EW'($signed(y_in));
  assign xr = (xe + $signed(EW'(Q_HALF))) >>> FRAC_BITS;
  assign yr = (ye + $signed(EW'(Q_HALF))) >>> FRAC_BITS;

  assign sx = SW'(xr) + SW'(SCREEN_W / 2);
  assign sy = SW'(SCREEN_H / 2) - SW'(yr);

  assign clip = (sx < 0) | (sx >= SW'(SCREEN_W))
              | (sy < 0) | (sy >= SW'(SCREEN_H));

  logic                   s1_v;
  logic                   s1_clip;
  logic [COORD_WIDTH-1:0] s1_x;
  logic [COORD_WIDTH-1:0] s1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_clip <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_clip <= clip;
        s1_x    <= sx[COORD_WIDTH-1:0];
        s1_y    <= sy[COORD_WIDTH-1:0];
      end
    end
  end

  ent_t  ent;
  ent_t  head;
  logic  push_ok;
  logic  clip_evt;
  logic  drop_evt;
  logic  full;
  logic  fvalid;

  assign ent.x    = s1_x;
  assign ent.y    = s1_y;
  assign ent.addr = ADDR_WIDTH'(s1_y) * ADDR_WIDTH'(SCREEN_W)
                  + ADDR_WIDTH'(s1_x);

  assign push_ok  = s1_v & ~s1_clip;
  assign clip_evt = s1_v & s1_clip;
  assign drop_evt = push_ok & full & ~(fvalid & out_ready);

  pixel_fifo #(
    .WIDTH($bits(ent_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_ok),
    .din  (ent),
    .pop  (out_ready),
    .dout (head),
    .valid(fvalid),
    .full (full),
    .level(fifo_level)
  );

  // Stale storage is hidden while the queue is empty
  assign out_valid = fvalid;
  assign pix_x     = fvalid ? head.x : '0;
  assign pix_y     = fvalid ? head.y : '0;
  assign pix_addr  = fvalid ? head.addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clipped_count <= '0;
      overflow      <= 1'b0;
    end else if (clr_stats) begin
      clipped_count <= '0;
      overflow      <= 1'b0;
    end else begin
      if (clip_evt && clipped_count != 16'hFFFF)
        clipped_count <= clipped_count + 16'd1;
      if (drop_evt)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_viewport_mapper.sv
// Bench for viewport_mapper: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_viewport_mapper;
  import graphics_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        clr_stats = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [14:0] pix_addr;
  logic [2:0]  fifo_level;
  logic [15:0] clipped_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  viewport_mapper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .clr_stats    (clr_stats),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_addr     (pix_addr),
    .fifo_level   (fifo_level),
    .clipped_count(clipped_count),
    .overflow     (overflow)
  );

  typedef struct {
    int x;
    int y;
    int addr;
  } exp_t;

  exp_t mq[$];
  bit   s1v;
  bit   s1clip;
  exp_t s1e;
  int   mcnt;
  bit   movf;

  function automatic void map(input logic [15:0] x, input logic [15:0] y,
                              output exp_t e, output bit c);
    int xs, ys, xi, yi;
    xs = int'($signed(x));
    ys = int'($signed(y));
    xi = (xs + 128) >>> 8;
    yi = (ys + 128) >>> 8;
    e.x = DEF_SCREEN_W / 2 + xi;
    e.y = DEF_SCREEN_H / 2 - yi;
    e.addr = e.y * DEF_SCREEN_W + e.x;
    c = e.x < 0 || e.x >= DEF_SCREEN_W || e.y < 0 || e.y >= DEF_SCREEN_H;
  endfunction

  task automatic model_step();
    bit   pop, nclip, clipe, drop;
    exp_t ne;
    if (!rst_n) begin
      mq.delete();
      s1v = 0;
      mcnt = 0;
      movf = 0;
      return;
    end
    pop = mq.size() != 0 && out_ready;
    map(x_in, y_in, ne, nclip);
    if (pop) void'(mq.pop_front());
    clipe = 0;
    drop = 0;
    if (s1v) begin
      if (s1clip) clipe = 1;
      else if (mq.size() < 4) mq.push_back(s1e);
      else drop = 1;
    end
    if (clr_stats) begin
      mcnt = 0;
      movf = 0;
    end else begin
      if (clipe && mcnt < 65535) mcnt++;
      if (drop) movf = 1;
    end
    s1v = in_valid;
    s1e = ne;
    s1clip = nclip;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [15:0] x, input logic [15:0] y);
    in_valid = v;
    x_in = x;
    y_in = y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_fifo: valid=%0b level=%0d want 0/0", out_valid, fifo_level);
    end
    checks++;
    if (clipped_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_stats: cnt=%0d ovf=%0b want 0/0", clipped_count, overflow);
    end
    checks++;
    if (pix_x !== 8'd0 || pix_y !== 8'd0 || pix_addr !== 15'd0) begin
      errors++;
      $display("FAIL reset_pix: %0d,%0d,%0d want 0,0,0", pix_x, pix_y, pix_addr);
    end
  endtask

  task automatic test_origin();
    out_ready = 1'b0;
    drive(1, 16'h0000, 16'h0000);
    tick();
    drive(0, 16'h0, 16'h0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL origin_early: valid=%0b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || pix_x !== 8'd80 || pix_y !== 8'd60 || pix_addr !== 15'd9680) begin
      errors++;
      $display("FAIL origin: v=%0b %0d,%0d,%0d want 1 80,60,9680",
               out_valid, pix_x, pix_y, pix_addr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_rounding();
    logic [15:0] xs[4];
    logic [15:0] ys[4];
    int ex[4];
    int ey[4];
    int ea[4];
    xs = '{16'h0A00, 16'h0180, 16'hFE80, 16'hB000};
    ys = '{16'h0500, 16'h0000, 16'h0000, 16'h3C00};
    ex = '{90, 82, 79, 0};
    ey = '{55, 60, 60, 0};
    ea = '{8890, 9682, 9679, 0};
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      drive(1, xs[i], ys[i]);
      tick();
      drive(0, 16'h0, 16'h0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || pix_x !== 8'(ex[i]) || pix_y !== 8'(ey[i])
          || pix_addr !== 15'(ea[i])) begin
        errors++;
        $display("FAIL round_%0d: v=%0b %0d,%0d,%0d want 1 %0d,%0d,%0d",
                 i, out_valid, pix_x, pix_y, pix_addr, ex[i], ey[i], ea[i]);
      end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clip();
    drive(1, 16'h5000, 16'h0000);
    tick();
    drive(0, 16'h0, 16'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || clipped_count !== 16'd1) begin
      errors++;
      $display("FAIL clip_right: v=%0b cnt=%0d want 0/1", out_valid, clipped_count);
    end
    drive(1, 16'h0000, 16'hC400);
    tick();
    drive(0, 16'h0, 16'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || clipped_count !== 16'd2) begin
      errors++;
      $display("FAIL clip_bottom: v=%0b cnt=%0d want 0/2", out_valid, clipped_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 16'(k * 256), 16'h0000);
      tick();
    end
    drive(0, 16'h0, 16'h0);
    tick();
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: level=%0d ovf=%0b want 4/1", fifo_level, overflow);
    end
    checks++;
    if (clipped_count !== 16'd2) begin
      errors++;
      $display("FAIL bp_cnt: cnt=%0d want 2", clipped_count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || pix_x !== 8'(80 + k)) begin
        errors++;
        $display("FAIL bp_order_%0d: v=%0b x=%0d want 1/%0d", k, out_valid, pix_x, 80 + k);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: v=%0b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    drive(1, 16'h5000, 16'h0000);
    tick();
    drive(0, 16'h0, 16'h0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (clipped_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: cnt=%0d ovf=%0b want 0/0", clipped_count, overflow);
    end
  endtask

  task automatic test_full_pushpop();
    int want[4];
    want = '{81, 82, 83, 85};
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 16'(k * 256), 16'h0000);
      tick();
    end
    drive(1, 16'h0500, 16'h0000);
    tick();
    drive(0, 16'h0, 16'h0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL pushpop: level=%0d ovf=%0b want 4/0", fifo_level, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || pix_x !== 8'(want[k])) begin
        errors++;
        $display("FAIL pushpop_order_%0d: v=%0b x=%0d want 1/%0d",
                 k, out_valid, pix_x, want[k]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0000, 16'(k * 256));
      tick();
    end
    drive(0, 16'h0, 16'h0);
    tick();
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL mid_fill: level=%0d want 3", fifo_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: v=%0b level=%0d want 0/0", out_valid, fifo_level);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL mid_after: v=%0b level=%0d want 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_random();
    exp_t h;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 0)
          drive(1, 16'($urandom), 16'($urandom));
        else
          drive(1, 16'(($urandom_range(0, 190) - 95) * 256 + $urandom_range(0, 255)),
                   16'(($urandom_range(0, 140) - 70) * 256 + $urandom_range(0, 255)));
      end else begin
        drive(0, 16'($urandom), 16'($urandom));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_stats = ($urandom_range(0, 39) == 0);
      tick();
      h = '{0, 0, 0};
      if (mq.size() != 0) h = mq[0];
      checks++;
      if (out_valid !== (mq.size() != 0) || fifo_level !== 3'(mq.size())) begin
        errors++;
        $display("FAIL rand_level_%0d: v=%0b lvl=%0d want lvl %0d",
                 n, out_valid, fifo_level, mq.size());
      end
      checks++;
      if (pix_x !== 8'(h.x) || pix_y !== 8'(h.y) || pix_addr !== 15'(h.addr)) begin
        errors++;
        $display("FAIL rand_pix_%0d: %0d,%0d,%0d want %0d,%0d,%0d",
                 n, pix_x, pix_y, pix_addr, h.x, h.y, h.addr);
      end
      checks++;
      if (clipped_count !== 16'(mcnt) || overflow !== movf) begin
        errors++;
        $display("FAIL rand_stats_%0d: cnt=%0d ovf=%0b want %0d/%0b",
                 n, clipped_count, overflow, mcnt, movf);
      end
    end
    drive(0, 16'h0, 16'h0);
    clr_stats = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_origin();
    test_rounding();
    test_clip();
    test_backpressure();
    test_clear();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
